// File: rtl/demux_scan_ctrl_pkg.sv
// Shared types and sizing for the demux scan controller and its bus interface.
package demux_scan_ctrl_pkg;
  localparam int CH_N  = 8;
  localparam int SEL_W = 3;

  typedef enum logic [1:0] {IDLE = 2'd0, DRIVE = 2'd1, DONE = 2'd2} scan_state_t;
endpackage

// File: rtl/demux_scan_ctrl_if.sv
// Frame handshake plus demux drive bus between an upstream source and the scan controller.
interface demux_scan_ctrl_if import demux_scan_ctrl_pkg::*; #(
  parameter int CNT_W = 8
) ();
  logic [CH_N-1:0]  frame_in;
  logic             frame_valid;
  logic             frame_ready;
  logic             abort;
  logic             dmx_in;
  logic             dmx_en;
  logic [SEL_W-1:0] dmx_sel;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] frame_cnt;

  modport master (
    output frame_in, frame_valid, abort,
    input  frame_ready, dmx_in, dmx_en, dmx_sel, busy, done, frame_cnt
  );

  modport slave (
    input  frame_in, frame_valid, abort,
    output frame_ready, dmx_in, dmx_en, dmx_sel, busy, done, frame_cnt
  );
endinterface

// File: rtl/demux_scan_ctrl_scan_dwell_timer.sv
// Counts the cycles spent on one demux channel and flags the final one.
module scan_dwell_timer #(
  parameter int DWELL = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic tick,
  output logic last_cycle
);
  localparam int TW = $clog2(DWELL + 1);

  logic [TW-1:0] cnt_q, cnt_d;

  assign last_cycle = (cnt_q == TW'(DWELL - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = '0;
    else if (tick)
      cnt_d = last_cycle ? '0 : cnt_q + TW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/eight_demux.sv
// 1-to-8 demultiplexer: routes d onto output sel while enabled, all outputs low otherwise.
module eight_demux (
  input  logic       d,
  input  logic       en,
  input  logic [2:0] sel,
  output logic [7:0] y
);
  always_comb begin
    y = '0;
    if (en) y[sel] = d;
  end
endmodule

// File: rtl/demux_scan_ctrl.sv
// Accepts 8-bit frames and scans them bit-by-bit onto an eight_demux, DWELL cycles per channel.
module demux_scan_ctrl import demux_scan_ctrl_pkg::*; #(
  parameter int DWELL     = 1,
  parameter int MSB_FIRST = 0,
  parameter int CNT_W     = 8
) (
  input logic              clk,
  input logic              rst_n,
  demux_scan_ctrl_if.slave bus
);
  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_DRIVE = DRIVE;
  localparam logic [1:0] S_DONE  = DONE;

  localparam logic [SEL_W-1:0] IDX_FIRST = (MSB_FIRST != 0) ? SEL_W'(CH_N - 1) : '0;
  localparam logic [SEL_W-1:0] IDX_LAST  = (MSB_FIRST != 0) ? '0 : SEL_W'(CH_N - 1);

  logic [1:0]       state_q, state_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic [CH_N-1:0]  frame_q, frame_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             din_q, din_d;
  logic             en_q, en_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ready_q, ready_d;
  logic             tmr_load, tmr_tick, last_cycle;

  scan_dwell_timer #(.DWELL(DWELL)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (tmr_load),
    .tick       (tmr_tick),
    .last_cycle (last_cycle)
  );

  // Every output is computed one cycle ahead so that the registered copy lines up with the state.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    frame_d  = frame_q;
    cnt_d    = cnt_q;
    sel_d    = sel_q;
    din_d    = 1'b0;
    en_d     = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    ready_d  = 1'b0;
    tmr_load = 1'b0;
    tmr_tick = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.frame_valid) begin
          frame_d  = bus.frame_in;
          idx_d    = IDX_FIRST;
          tmr_load = 1'b1;
          state_d  = S_DRIVE;
          en_d     = 1'b1;
          busy_d   = 1'b1;
          sel_d    = IDX_FIRST;
          din_d    = bus.frame_in[IDX_FIRST];
        end else begin
          ready_d  = 1'b1;
        end
      end
      S_DRIVE: begin
        tmr_tick = 1'b1;
        if (bus.abort) begin
          state_d = S_IDLE;
          ready_d = 1'b1;
        end else if (last_cycle && idx_q == IDX_LAST) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          cnt_d   = cnt_q + CNT_W'(1);
        end else begin
          if (last_cycle)
            idx_d = (MSB_FIRST != 0) ? idx_q - SEL_W'(1) : idx_q + SEL_W'(1);
          en_d   = 1'b1;
          busy_d = 1'b1;
          sel_d  = idx_d;
          din_d  = frame_q[idx_d];
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      frame_q <= '0;
      cnt_q   <= '0;
      sel_q   <= '0;
      din_q   <= 1'b0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      frame_q <= frame_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      din_q   <= din_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

  assign bus.frame_ready = ready_q;
  assign bus.dmx_in      = din_q;
  assign bus.dmx_en      = en_q;
  assign bus.dmx_sel     = sel_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.frame_cnt   = cnt_q;
endmodule

// File: tb/tb_demux_scan_ctrl.sv
// Two scan controllers (LSB-first DWELL=1 CNT_W=2, MSB-first DWELL=3) checked against a
// cycle-offset reference model plus directed literal expectations.
module tb_demux_scan_ctrl;
  import demux_scan_ctrl_pkg::*;

  localparam int DW_A = 1, MF_A = 0, CW_A = 2;
  localparam int DW_B = 3, MF_B = 1, CW_B = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a_n, rst_b_n;
  logic [7:0] y_a, y_b;

  demux_scan_ctrl_if #(.CNT_W(CW_A)) bus_a ();
  demux_scan_ctrl_if #(.CNT_W(CW_B)) bus_b ();

  demux_scan_ctrl #(.DWELL(DW_A), .MSB_FIRST(MF_A), .CNT_W(CW_A)) dut_a (
    .clk(clk), .rst_n(rst_a_n), .bus(bus_a.slave));
  demux_scan_ctrl #(.DWELL(DW_B), .MSB_FIRST(MF_B), .CNT_W(CW_B)) dut_b (
    .clk(clk), .rst_n(rst_b_n), .bus(bus_b.slave));

  eight_demux dmx_a (.d(bus_a.dmx_in), .en(bus_a.dmx_en), .sel(bus_a.dmx_sel), .y(y_a));
  eight_demux dmx_b (.d(bus_b.dmx_in), .en(bus_b.dmx_en), .sel(bus_b.dmx_sel), .y(y_b));

  int n_checks = 0;
  int n_errors = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: an accepted frame is just an offset k counted from the accept edge.
  // k in [0, 8*DWELL) is driving channel k/DWELL (mirrored for MSB-first), k == 8*DWELL is done.
  int         dw[2]    = '{DW_A, DW_B};
  int         mf[2]    = '{MF_A, MF_B};
  int         cmask[2] = '{(1 << CW_A) - 1, (1 << CW_B) - 1};
  bit         started[2];
  bit         m_act[2];
  int         m_k[2];
  logic [7:0] m_frame[2];
  int         m_cnt[2];
  int         m_sel[2];

  function automatic int ch_of(input int i, input int k);
    int p = k / dw[i];
    return (mf[i] != 0) ? 7 - p : p;
  endfunction

  function automatic void model_step(input int i, input logic rn, input logic v,
                                     input logic [7:0] f, input logic ab);
    if (!rn) begin
      started[i] = 1'b1;
      m_act[i] = 1'b0; m_k[i] = 0; m_cnt[i] = 0; m_sel[i] = 0; m_frame[i] = '0;
    end else if (!m_act[i]) begin
      if (v) begin
        m_act[i] = 1'b1; m_k[i] = 0; m_frame[i] = f; m_sel[i] = ch_of(i, 0);
      end
    end else if (m_k[i] < 8 * dw[i] && ab) begin
      m_act[i] = 1'b0;
    end else begin
      m_k[i]++;
      if (m_k[i] == 8 * dw[i])     m_cnt[i] = (m_cnt[i] + 1) & cmask[i];
      else if (m_k[i] > 8 * dw[i]) m_act[i] = 1'b0;
      else                         m_sel[i] = ch_of(i, m_k[i]);
    end
  endfunction

  function automatic void cmp(input int i, input logic rdy, input logic en, input logic din,
                              input logic bsy, input logic dn, input logic [2:0] sel,
                              input logic [31:0] cnt, input logic [7:0] y);
    string p = (i == 0) ? "A" : "B";
    logic e_en, e_dn, e_in;
    logic [7:0] e_y;
    int k = m_k[i];
    e_en = m_act[i] && (k < 8 * dw[i]);
    e_dn = m_act[i] && (k == 8 * dw[i]);
    e_in = e_en ? m_frame[i][ch_of(i, k)] : 1'b0;
    e_y  = '0;
    if (e_en && e_in) e_y[m_sel[i]] = 1'b1;
    chk({p, ".frame_ready"}, 32'(rdy), 32'(!m_act[i]));
    chk({p, ".dmx_en"},      32'(en),  32'(e_en));
    chk({p, ".busy"},        32'(bsy), 32'(e_en));
    chk({p, ".done"},        32'(dn),  32'(e_dn));
    chk({p, ".dmx_in"},      32'(din), 32'(e_in));
    chk({p, ".dmx_sel"},     32'(sel), 32'(m_sel[i]));
    chk({p, ".frame_cnt"},   cnt,      32'(m_cnt[i]));
    chk({p, ".demux_y"},     32'(y),   32'(e_y));
  endfunction

  always @(posedge clk) begin
    model_step(0, rst_a_n, bus_a.frame_valid, bus_a.frame_in, bus_a.abort);
    model_step(1, rst_b_n, bus_b.frame_valid, bus_b.frame_in, bus_b.abort);
  end

  always @(negedge clk) begin
    if (started[0])
      cmp(0, bus_a.frame_ready, bus_a.dmx_en, bus_a.dmx_in, bus_a.busy, bus_a.done,
          bus_a.dmx_sel, 32'(bus_a.frame_cnt), y_a);
    if (started[1])
      cmp(1, bus_b.frame_ready, bus_b.dmx_en, bus_b.dmx_in, bus_b.busy, bus_b.done,
          bus_b.dmx_sel, 32'(bus_b.frame_cnt), y_b);
  end

  task automatic run_a();
    logic [7:0] pat = 8'hA5;
    int exp_cnt[5] = '{1, 2, 3, 0, 1};
    int n_done, last, seen;
    rst_a_n = 1'b0;
    bus_a.frame_valid = 1'b0; bus_a.frame_in = '0; bus_a.abort = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("A.rst_ready", 32'(bus_a.frame_ready), 32'd1);
      chk("A.rst_en",    32'(bus_a.dmx_en),      32'd0);
      chk("A.rst_cnt",   32'(bus_a.frame_cnt),   32'd0);
      chk("A.rst_done",  32'(bus_a.done),        32'd0);
    end
    @(posedge clk); #1;
    rst_a_n = 1'b1; bus_a.frame_valid = 1'b1; bus_a.frame_in = 8'hA5;
    @(posedge clk); #1;
    bus_a.frame_valid = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("A.a5_sel", 32'(bus_a.dmx_sel), 32'(c));
      chk("A.a5_in",  32'(bus_a.dmx_in),  32'(pat[c]));
      chk("A.a5_en",  32'(bus_a.dmx_en),  32'd1);
    end
    @(negedge clk);
    chk("A.a5_done", 32'(bus_a.done),      32'd1);
    chk("A.a5_cnt",  32'(bus_a.frame_cnt), 32'd1);
    @(negedge clk);
    chk("A.a5_ready", 32'(bus_a.frame_ready), 32'd1);

    // abort in the 4th drive cycle, then a new frame two cycles later
    @(posedge clk); #1;
    bus_a.frame_valid = 1'b1; bus_a.frame_in = 8'hFF;
    @(posedge clk); #1;
    bus_a.frame_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 bus_a.abort = 1'b1;
    @(posedge clk); #1;
    bus_a.abort = 1'b0; bus_a.frame_valid = 1'b1; bus_a.frame_in = 8'h3C;
    @(negedge clk);
    chk("A.abort_en",    32'(bus_a.dmx_en),      32'd0);
    chk("A.abort_done",  32'(bus_a.done),        32'd0);
    chk("A.abort_cnt",   32'(bus_a.frame_cnt),   32'd1);
    chk("A.abort_ready", 32'(bus_a.frame_ready), 32'd1);
    @(posedge clk); #1;
    bus_a.frame_valid = 1'b0;
    @(negedge clk);
    chk("A.reacc_en",  32'(bus_a.dmx_en),  32'd1);
    chk("A.reacc_sel", 32'(bus_a.dmx_sel), 32'd0);
    seen = 0;
    for (int c = 0; c < 20 && seen == 0; c++) begin
      @(negedge clk);
      if (bus_a.done) seen = 1;
    end
    chk("A.reacc_done_seen", 32'(seen), 32'd1);
    chk("A.reacc_cnt", 32'(bus_a.frame_cnt), 32'd2);

    // reset in the 5th drive cycle
    @(posedge clk); #1;
    bus_a.frame_valid = 1'b1; bus_a.frame_in = 8'hFF;
    @(posedge clk); #1;
    bus_a.frame_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_a_n = 1'b0;
    @(posedge clk); #1;
    rst_a_n = 1'b1;
    @(negedge clk);
    chk("A.midrst_ready", 32'(bus_a.frame_ready), 32'd1);
    chk("A.midrst_en",    32'(bus_a.dmx_en),      32'd0);
    chk("A.midrst_cnt",   32'(bus_a.frame_cnt),   32'd0);
    chk("A.midrst_sel",   32'(bus_a.dmx_sel),     32'd0);
    chk("A.midrst_done",  32'(bus_a.done),        32'd0);

    // back-to-back frames with frame_valid held high
    @(posedge clk); #1;
    bus_a.frame_valid = 1'b1; bus_a.frame_in = 8'($urandom);
    n_done = 0; last = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (bus_a.done) begin
        if (n_done > 0) chk("A.b2b_spacing", 32'(c - last), 32'd10);
        chk("A.b2b_cnt", 32'(bus_a.frame_cnt), 32'(exp_cnt[n_done]));
        last = c;
        n_done++;
        if (n_done == 5) begin
          bus_a.frame_valid = 1'b0;
          break;
        end
      end
    end
    chk("A.b2b_frames", 32'(n_done), 32'd5);

    for (int n = 0; n < 2000; n++) begin
      @(posedge clk); #1;
      rst_a_n           = ($urandom_range(99, 0) != 0);
      bus_a.frame_valid = 1'($urandom);
      bus_a.frame_in    = 8'($urandom);
      bus_a.abort       = ($urandom_range(19, 0) == 0);
    end
    @(posedge clk); #1;
    rst_a_n = 1'b1; bus_a.frame_valid = 1'b0; bus_a.abort = 1'b0;
    repeat (30) @(posedge clk);
  endtask

  task automatic run_b();
    int s;
    rst_b_n = 1'b0;
    bus_b.frame_valid = 1'b0; bus_b.frame_in = '0; bus_b.abort = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("B.rst_ready", 32'(bus_b.frame_ready), 32'd1);
      chk("B.rst_en",    32'(bus_b.dmx_en),      32'd0);
      chk("B.rst_cnt",   32'(bus_b.frame_cnt),   32'd0);
    end
    @(posedge clk); #1;
    rst_b_n = 1'b1; bus_b.frame_valid = 1'b1; bus_b.frame_in = 8'h81;
    @(posedge clk); #1;
    bus_b.frame_valid = 1'b0;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      s = 7 - c / 3;
      chk("B.81_sel", 32'(bus_b.dmx_sel), 32'(s));
      chk("B.81_in",  32'(bus_b.dmx_in),  32'((s == 7 || s == 0) ? 1 : 0));
      chk("B.81_en",  32'(bus_b.dmx_en),  32'd1);
    end
    @(negedge clk);
    chk("B.81_done", 32'(bus_b.done),      32'd1);
    chk("B.81_cnt",  32'(bus_b.frame_cnt), 32'd1);
    chk("B.81_sel_hold", 32'(bus_b.dmx_sel), 32'd0);

    for (int n = 0; n < 2000; n++) begin
      @(posedge clk); #1;
      rst_b_n           = ($urandom_range(199, 0) != 0);
      bus_b.frame_valid = ($urandom_range(2, 0) == 0);
      bus_b.frame_in    = 8'($urandom);
      bus_b.abort       = ($urandom_range(39, 0) == 0);
    end
    @(posedge clk); #1;
    rst_b_n = 1'b1; bus_b.frame_valid = 1'b0; bus_b.abort = 1'b0;
    repeat (40) @(posedge clk);
  endtask

  initial begin
    fork
      run_a();
      run_b();
    join
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got %0t expected completion", $time);
    $fatal(1, "watchdog");
  end
endmodule
